// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory cycles,
// sub-word load extraction/extension and read-modify-write sub-word stores.
module load_store_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD_RD, RMW_RD, ST_WR, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              size_reg;
    logic                    unsigned_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             rdata_reg;
    logic                    err_reg;

    logic                    accept;
    logic                    req_err;
    logic [31:0]             byte_shift;
    logic [15:0]             half_sel;
    logic [31:0]             load_ext;
    logic [31:0]             merged;

    assign accept = (state_reg == IDLE) && req_valid;

    // With alignment checking off, misaligned halves/words simply use the aligned lane.
    always_comb begin
        req_err = (req_size == 2'b11);
        if (CHECK_ALIGN) begin
            if (req_size == 2'b01 && req_addr[0])
                req_err = 1'b1;
            if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                req_err = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_we)
                        state_next = LD_RD;
                    else if (req_size == 2'b10)
                        state_next = ST_WR;
                    else
                        state_next = RMW_RD;
                end
            end
            LD_RD:   state_next = RESP;
            RMW_RD:  state_next = ST_WR;
            ST_WR:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    assign byte_shift = mem_rdata >> {addr_reg[1:0], 3'b000};
    assign half_sel   = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (size_reg)
            2'b00:   load_ext = {{24{~unsigned_reg & byte_shift[7]}}, byte_shift[7:0]};
            2'b01:   load_ext = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Each byte lane takes the store data if addressed, otherwise keeps the read word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       hit;
            logic [7:0] src;
            always_comb begin
                if (size_reg == 2'b00) begin
                    hit = (addr_reg[1:0] == 2'(gi));
                    src = wdata_reg[7:0];
                end else begin
                    hit = (addr_reg[1] == 1'(gi / 2));
                    src = wdata_reg[8*(gi%2) +: 8];
                end
            end
            assign merged[8*gi +: 8] = hit ? src : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                size_reg     <= req_size;
                unsigned_reg <= req_unsigned;
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                rdata_reg    <= 32'h0;
                err_reg      <= req_err;
            end
            if (state_reg == LD_RD)
                rdata_reg <= load_ext;
            if (state_reg == RMW_RD)
                wdata_reg <= merged;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_valid ? rdata_reg : 32'h0;
    assign resp_err   = resp_valid & err_reg;
    assign mem_read   = (state_reg == LD_RD) || (state_reg == RMW_RD);
    assign mem_write  = (state_reg == ST_WR);
    assign mem_addr   = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata  = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts
// each response; a monitor pops and compares when resp_valid is seen.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory the DUT drives: combinational read, write on rising edge.
    logic [31:0] tbmem [16];
    assign mem_rdata = mem_read ? tbmem[mem_addr[5:2]] : 32'h0;
    always @(posedge clk) if (mem_write) tbmem[mem_addr[5:2]] <= mem_wdata;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int tests = 0;
    int failed = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          acc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [16];

    // Reference model: word array updated by the architectural effect of each request.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd, input int acc);
        exp_t        e;
        logic [31:0] w, v, mask;
        int          bsh, hsh;
        w   = ref_mem[addr[5:2]];
        bsh = 8 * int'(addr[1:0]);
        hsh = 16 * int'(addr[1]);
        e.acc = acc; e.rdata = 32'h0; e.err = 1'b0; e.nrd = 0; e.nwr = 0;
        if (sz == 2'd3 || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)) begin
            e.err = 1'b1; e.lat = 1;
        end else if (!we) begin
            e.lat = 2; e.nrd = 1;
            if (sz == 2'd0) begin
                v = (w >> bsh) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end else if (sz == 2'd1) begin
                v = (w >> hsh) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            e.rdata = v;
        end else begin
            e.nwr = 1;
            if (sz == 2'd2) begin
                e.lat = 2; w = wd;
            end else begin
                e.lat = 3; e.nrd = 1;
                if (sz == 2'd0) begin
                    mask = 32'hFF << bsh;
                    w = (w & ~mask) | ((wd & 32'hFF) << bsh);
                end else begin
                    mask = 32'hFFFF << hsh;
                    w = (w & ~mask) | ((wd & 32'hFFFF) << hsh);
                end
            end
            ref_mem[addr[5:2]] = w;
        end
        return e;
    endfunction

    int          nrd_cnt = 0;
    int          nwr_cnt = 0;
    int          resp_prev = 0;
    int          resp_last = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrd_cnt = 0;
                nwr_cnt = 0;
            end else begin
                if (mem_read || mem_write)
                    check("mem_addr_bits", {mem_addr[31:6], mem_addr[1:0]}, 32'h0);
                if (mem_read) nrd_cnt++;
                if (mem_write) begin
                    nwr_cnt++;
                    last_wr_data = mem_wdata;
                end
                if (resp_valid) begin
                    resp_prev  = resp_last;
                    resp_last  = cycle;
                    last_rdata = resp_rdata;
                    if (expq.size() == 0) begin
                        check("unexpected_resp_valid", 32'(resp_valid), 32'h0);
                    end else begin
                        e = expq.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("latency", 32'(cycle - e.acc + 1), 32'(e.lat));
                        check("mem_read_cycles", 32'(nrd_cnt), 32'(e.nrd));
                        check("mem_write_cycles", 32'(nwr_cnt), 32'(e.nwr));
                        $display("[TB] resp cyc=%0d rdata=%h err=%0d", cycle, resp_rdata, resp_err);
                    end
                    nrd_cnt = 0;
                    nwr_cnt = 0;
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, input bit push);
        int   guard;
        exp_t e;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        if (push) begin
            e = model(we, sz, uns, addr, wd, cycle + 1);
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (expq.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (expq.size() != 0) begin
            check("response_timeout", 32'(expq.size()), 32'h0);
            expq.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          hold;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_resp", {resp_rdata[30:0], resp_err}, 32'h0);
        check("rst_mem_addr_wdata", mem_addr | mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Word store then word load
        do_req(1'b1, 2'd2, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1); wait_drain();
        check("sw_wdata", last_wr_data, 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1); wait_drain();
        check("lw0", last_rdata, 32'hDEADBEEF);

        // Sub-word loads
        do_req(1'b0, 2'd0, 1'b0, 32'd1, 32'h0, 1'b0, 1'b1); wait_drain();
        check("lb1", last_rdata, 32'hFFFFFFBE);
        do_req(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b1); wait_drain();
        check("lbu3", last_rdata, 32'h000000DE);
        do_req(1'b0, 2'd1, 1'b0, 32'd2, 32'h0, 1'b0, 1'b1); wait_drain();
        check("lh2", last_rdata, 32'hFFFFDEAD);
        do_req(1'b0, 2'd1, 1'b1, 32'd0, 32'h0, 1'b0, 1'b1); wait_drain();
        check("lhu0", last_rdata, 32'h0000BEEF);

        // Read-modify-write stores
        do_req(1'b1, 2'd0, 1'b0, 32'd2, 32'h12345678, 1'b0, 1'b1); wait_drain();
        check("sb_merge", last_wr_data, 32'hDE78BEEF);
        do_req(1'b1, 2'd1, 1'b0, 32'd0, 32'h0000CAFE, 1'b0, 1'b1); wait_drain();
        check("sh_merge", last_wr_data, 32'hDE78CAFE);

        // Errors: misaligned half, misaligned word, illegal size
        do_req(1'b1, 2'd1, 1'b0, 32'd1, 32'h11111111, 1'b0, 1'b1); wait_drain();
        do_req(1'b1, 2'd2, 1'b0, 32'd6, 32'h22222222, 1'b0, 1'b1); wait_drain();
        do_req(1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1); wait_drain();

        // Reset asserted while the byte store is in its read phase
        do_req(1'b1, 2'd0, 1'b0, 32'd0, 32'h000000AA, 1'b0, 1'b0);
        check("rmw_read_phase", 32'(mem_read), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        check("rst_word0_tbmem", tbmem[0], 32'hDE78CAFE);
        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1); wait_drain();
        check("rst_word0_load", last_rdata, 32'hDE78CAFE);

        // Back-to-back word loads with req_valid held
        do_req(1'b1, 2'd2, 1'b0, 32'd4, 32'h0BADF00D, 1'b0, 1'b1); wait_drain();
        do_req(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 1'b0, 1'b1); wait_drain();
        check("b2b_resp_gap", 32'(resp_last - resp_prev), 32'd3);
        check("b2b_second_rdata", last_rdata, 32'h0BADF00D);

        // Fill remaining words, then randomized traffic
        for (int i = 2; i < 16; i++) begin
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b1);
            wait_drain();
        end
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            hold = ($urandom_range(0, 3) == 0);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom, hold, 1'b1);
            if (!hold) wait_drain();
        end
        req_valid = 1'b0;
        wait_drain();

        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem[%0d]", i), tbmem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
